// File: rtl/multi_alarm_clock.sv
// HH:MM:SS time-of-day clock advanced by a prescaled seconds tick, with
// NUM_ALARMS independent alarm channels (arm/disarm, ack, snooze, ring timeout).
module multi_alarm_clock #(
    parameter int NUM_ALARMS    = 4,
    parameter int TICKS_PER_SEC = 1,
    parameter int RING_SECS     = 30,
    parameter int SNOOZE_SECS   = 300,
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_time,
    input  logic [5:0]            time_hh,
    input  logic [5:0]            time_mm,
    input  logic [5:0]            time_ss,
    input  logic                  alarm_wr,
    input  logic [SEL_W-1:0]      alarm_sel,
    input  logic                  alarm_arm,
    input  logic [5:0]            alarm_hh,
    input  logic [5:0]            alarm_mm,
    input  logic [5:0]            alarm_ss,
    input  logic                  ack,
    input  logic                  snooze,
    output logic [5:0]            current_hh,
    output logic [5:0]            current_mm,
    output logic [5:0]            current_ss,
    output logic                  sec_pulse,
    output logic [NUM_ALARMS-1:0] alarm_active,
    output logic                  alarm
);
    localparam int PRE_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_DISARMED,
        ST_ARMED,
        ST_RINGING,
        ST_SNOOZED
    } ch_state_t;

    // Channel states live in one named array so they are visible for debug.
    ch_state_t        ch_state   [NUM_ALARMS];
    ch_state_t        ch_state_d [NUM_ALARMS];
    logic [CNT_W-1:0] ch_cnt     [NUM_ALARMS];
    logic [CNT_W-1:0] ch_cnt_d   [NUM_ALARMS];
    logic [5:0]       alm_hh     [NUM_ALARMS];
    logic [5:0]       alm_mm     [NUM_ALARMS];
    logic [5:0]       alm_ss     [NUM_ALARMS];

    logic [PRE_W-1:0]      presc;
    logic                  tick;
    logic                  time_ok;
    logic                  alarm_ok;
    logic [NUM_ALARMS-1:0] wr_v;
    logic [NUM_ALARMS-1:0] match_v;
    logic [NUM_ALARMS-1:0] ring_d;

    // Commands (set_time, alarm_wr, ack, snooze) are one-cycle strobes sampled
    // on every rising edge; there is no back-pressure, a valid command always lands.
    assign tick     = (presc == PRE_W'(TICKS_PER_SEC - 1));
    assign time_ok  = (time_hh <= 6'd23) && (time_mm <= 6'd59) && (time_ss <= 6'd59);
    assign alarm_ok = (alarm_hh <= 6'd23) && (alarm_mm <= 6'd59) && (alarm_ss <= 6'd59) &&
                      (int'(alarm_sel) < NUM_ALARMS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc      <= '0;
            sec_pulse  <= 1'b0;
            current_hh <= '0;
            current_mm <= '0;
            current_ss <= '0;
        end else begin
            sec_pulse <= 1'b0;
            if (set_time && time_ok) begin
                presc      <= '0;
                current_hh <= time_hh;
                current_mm <= time_mm;
                current_ss <= time_ss;
            end else if (tick) begin
                presc     <= '0;
                sec_pulse <= 1'b1;
                if (current_ss == 6'd59) begin
                    current_ss <= '0;
                    if (current_mm == 6'd59) begin
                        current_mm <= '0;
                        current_hh <= (current_hh == 6'd23) ? 6'd0 : current_hh + 6'd1;
                    end else begin
                        current_mm <= current_mm + 6'd1;
                    end
                end else begin
                    current_ss <= current_ss + 6'd1;
                end
            end else begin
                presc <= presc + PRE_W'(1);
            end
        end
    end

    // A match is only meaningful in the cycle after the time advanced, so a
    // freshly loaded time (no sec_pulse) can never trigger a channel.
    always_comb begin
        wr_v    = '0;
        match_v = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            wr_v[i]    = alarm_wr && alarm_ok && (int'(alarm_sel) == i);
            match_v[i] = sec_pulse && (current_hh == alm_hh[i]) &&
                         (current_mm == alm_mm[i]) && (current_ss == alm_ss[i]);
        end
    end

    always_comb begin
        ring_d = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            ch_state_d[i] = ch_state[i];
            ch_cnt_d[i]   = ch_cnt[i];
            if (wr_v[i]) begin
                ch_state_d[i] = alarm_arm ? ST_ARMED : ST_DISARMED;
                ch_cnt_d[i]   = '0;
            end else begin
                case (ch_state[i])
                    ST_ARMED: begin
                        if (match_v[i]) begin
                            ch_state_d[i] = ST_RINGING;
                            ch_cnt_d[i]   = CNT_W'(RING_SECS);
                        end
                    end
                    ST_RINGING: begin
                        if (ack) begin
                            ch_state_d[i] = ST_ARMED;
                            ch_cnt_d[i]   = '0;
                        end else if (snooze) begin
                            ch_state_d[i] = ST_SNOOZED;
                            ch_cnt_d[i]   = CNT_W'(SNOOZE_SECS);
                        end else if (sec_pulse) begin
                            if (ch_cnt[i] == CNT_W'(1)) begin
                                ch_state_d[i] = ST_ARMED;
                                ch_cnt_d[i]   = '0;
                            end else begin
                                ch_cnt_d[i] = ch_cnt[i] - CNT_W'(1);
                            end
                        end
                    end
                    ST_SNOOZED: begin
                        if (ack) begin
                            ch_state_d[i] = ST_ARMED;
                            ch_cnt_d[i]   = '0;
                        end else if (sec_pulse) begin
                            if (ch_cnt[i] == CNT_W'(1)) begin
                                ch_state_d[i] = ST_RINGING;
                                ch_cnt_d[i]   = CNT_W'(RING_SECS);
                            end else begin
                                ch_cnt_d[i] = ch_cnt[i] - CNT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
            ring_d[i] = (ch_state_d[i] == ST_RINGING);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                ch_state[i] <= ST_DISARMED;
                ch_cnt[i]   <= '0;
                alm_hh[i]   <= '0;
                alm_mm[i]   <= '0;
                alm_ss[i]   <= '0;
            end
            alarm_active <= '0;
            alarm        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                ch_state[i] <= ch_state_d[i];
                ch_cnt[i]   <= ch_cnt_d[i];
                if (wr_v[i]) begin
                    alm_hh[i] <= alarm_hh;
                    alm_mm[i] <= alarm_mm;
                    alm_ss[i] <= alarm_ss;
                end
            end
            alarm_active <= ring_d;
            alarm        <= |ring_d;
        end
    end

endmodule
